// File: rtl/uart_command_decoder.sv
// uart_command_decoder: assembles two-byte (command, address) frames from the
// UART receive byte stream, validates them with an inter-byte timeout, and
// emits a single-cycle command strobe or an error strobe with a reason code.
module uart_command_decoder #(
    parameter int TIMEOUT_CYCLES = 43400,
    parameter int NUM_COMMANDS   = 7,
    parameter int MAX_ADDRESS    = 31
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       has_data,
    input  logic [7:0] data_received,
    output logic       command_ready,
    output logic [7:0] command,
    output logic [7:0] address,
    output logic       frame_error,
    output logic [1:0] error_code,
    output logic [2:0] debug_state
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    localparam logic [1:0] ERR_BAD_CMD  = 2'b01;
    localparam logic [1:0] ERR_BAD_ADDR = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_ADDR = 3'd1,
        ST_VALIDATE  = 3'd2,
        ST_DONE      = 3'd3,
        ST_ERROR     = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       cmd_int_q, cmd_int_d;
    logic [7:0]       addr_int_q, addr_int_d;
    logic [7:0]       command_q, command_d;
    logic [7:0]       address_q, address_d;
    logic [1:0]       error_code_q, error_code_d;
    logic             command_ready_q, command_ready_d;
    logic             frame_error_q, frame_error_d;
    logic             cmd_bad_s;
    logic             addr_bad_s;

    // Range checks on the latched frame bytes, done at 32 bits so any
    // parameter value compares correctly.
    always_comb begin
        cmd_bad_s  = ({24'd0, cmd_int_q} >= NUM_COMMANDS);
        addr_bad_s = ({24'd0, addr_int_q} > MAX_ADDRESS);
    end

    // Next-state and next-register computation for the frame FSM.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cmd_int_d    = cmd_int_q;
        addr_int_d   = addr_int_q;
        command_d    = command_q;
        address_d    = address_q;
        error_code_d = error_code_q;
        case (state_q)
            ST_IDLE: begin
                if (has_data) begin
                    cmd_int_d = data_received;
                    cnt_d     = '0;
                    state_d   = ST_WAIT_ADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_ADDR: begin
                // Saturating count; a byte arriving on the terminal count wins.
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                if (has_data) begin
                    addr_int_d = data_received;
                    state_d    = ST_VALIDATE;
                end else if (cnt_q == CNT_LAST) begin
                    error_code_d = ERR_TIMEOUT;
                    state_d      = ST_ERROR;
                end else begin
                    state_d = ST_WAIT_ADDR;
                end
            end
            ST_VALIDATE: begin
                if (cmd_bad_s) begin
                    error_code_d = ERR_BAD_CMD;
                    state_d      = ST_ERROR;
                end else if (addr_bad_s) begin
                    error_code_d = ERR_BAD_ADDR;
                    state_d      = ST_ERROR;
                end else begin
                    command_d = cmd_int_q;
                    address_d = addr_int_q;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_ERROR: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        // Strobes are registered versions of the state they belong to.
        command_ready_d = (state_d == ST_DONE);
        frame_error_d   = (state_d == ST_ERROR);
    end

    // Single state/register bank with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            cmd_int_q       <= 8'h00;
            addr_int_q      <= 8'h00;
            command_q       <= 8'h00;
            address_q       <= 8'h00;
            error_code_q    <= 2'b00;
            command_ready_q <= 1'b0;
            frame_error_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            cmd_int_q       <= cmd_int_d;
            addr_int_q      <= addr_int_d;
            command_q       <= command_d;
            address_q       <= address_d;
            error_code_q    <= error_code_d;
            command_ready_q <= command_ready_d;
            frame_error_q   <= frame_error_d;
        end
    end

    assign command_ready = command_ready_q;
    assign frame_error   = frame_error_q;
    assign command       = command_q;
    assign address       = address_q;
    assign error_code    = error_code_q;
    assign debug_state   = state_q;

endmodule

// File: tb/tb_uart_command_decoder.sv
// Bench for uart_command_decoder: directed frames with literal expectations,
// then randomized byte streams, all checked every cycle against a
// timestamp-based frame model.
module tb_uart_command_decoder;

    localparam int TO   = 100;
    localparam int NCMD = 7;
    localparam int MAXA = 31;

    logic       clock;
    logic       reset;
    logic       has_data;
    logic [7:0] data_received;
    logic       command_ready;
    logic [7:0] command;
    logic [7:0] address;
    logic       frame_error;
    logic [1:0] error_code;
    logic [2:0] debug_state;

    uart_command_decoder #(
        .TIMEOUT_CYCLES(TO),
        .NUM_COMMANDS  (NCMD),
        .MAX_ADDRESS   (MAXA)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .has_data     (has_data),
        .data_received(data_received),
        .command_ready(command_ready),
        .command      (command),
        .address      (address),
        .frame_error  (frame_error),
        .error_code   (error_code),
        .debug_state  (debug_state)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_cmp = 0;
    int n_err = 0;
    bit check_en = 1'b0;

    // Model: frames tracked by edge numbers rather than a state machine.
    longint     cyc = 0;
    bit         m_wait = 1'b0;
    longint     m_tfirst = 0;
    longint     m_pend = -1;
    longint     m_busy = -1;
    logic [7:0] m_b1 = 8'h00;
    logic [7:0] m_cmd = 8'h00;
    logic [7:0] m_addr = 8'h00;
    logic [1:0] m_code = 2'b00;
    bit         p_ok = 1'b0;
    logic [7:0] p_cmd = 8'h00;
    logic [7:0] p_addr = 8'h00;
    logic [1:0] p_code = 2'b00;
    bit         e_rdy = 1'b0;
    bit         e_err = 1'b0;
    int         e_state = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance the model by one rising edge with the inputs sampled there.
    task automatic model_step(input bit r, input bit h, input logic [7:0] d);
        cyc++;
        e_rdy = 1'b0;
        e_err = 1'b0;
        if (r) begin
            m_wait = 1'b0; m_pend = -1; m_busy = -1;
            m_cmd = 8'h00; m_addr = 8'h00; m_code = 2'b00;
            e_state = 0;
        end else if (cyc == m_pend) begin
            if (p_ok) begin
                m_cmd = p_cmd; m_addr = p_addr; e_rdy = 1'b1; e_state = 3;
            end else begin
                m_code = p_code; e_err = 1'b1; e_state = 4;
            end
        end else if (cyc <= m_busy) begin
            e_state = 0;
        end else if (m_wait) begin
            if (h) begin
                p_cmd  = m_b1;
                p_addr = d;
                if (int'(m_b1) >= NCMD) begin
                    p_ok = 1'b0; p_code = 2'b01;
                end else if (int'(d) > MAXA) begin
                    p_ok = 1'b0; p_code = 2'b10;
                end else begin
                    p_ok = 1'b1;
                end
                m_pend = cyc + 1;
                m_busy = cyc + 2;
                m_wait = 1'b0;
                e_state = 2;
            end else if (cyc - m_tfirst == TO) begin
                m_code = 2'b11; e_err = 1'b1; e_state = 4;
                m_busy = cyc + 1;
                m_wait = 1'b0;
            end else begin
                e_state = 1;
            end
        end else if (h) begin
            m_wait = 1'b1; m_tfirst = cyc; m_b1 = d; e_state = 1;
        end else begin
            e_state = 0;
        end
    endtask

    // Every-cycle comparison against the model, mid-cycle.
    initial begin
        forever begin
            @(negedge clock);
            if (check_en) begin
                chk("command_ready", int'(command_ready), int'(e_rdy));
                chk("frame_error", int'(frame_error), int'(e_err));
                chk("command", int'(command), int'(m_cmd));
                chk("address", int'(address), int'(m_addr));
                chk("error_code", int'(error_code), int'(m_code));
                chk("debug_state", int'(debug_state), e_state);
            end
        end
    end

    task automatic cycle(input bit r, input bit h, input logic [7:0] d);
        reset = r;
        has_data = h;
        data_received = d;
        @(posedge clock);
        model_step(r, h, d);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        has_data = 1'b0;
        data_received = 8'h00;
        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 8'h00);
        check_en = 1'b1;
        chk("rst_state", int'(debug_state), 0);
        chk("rst_cmd", int'(command), 0);
        chk("rst_code", int'(error_code), 0);
        chk("rst_rdy", int'(command_ready), 0);

        // Valid frame 0x03, 0x05
        cycle(1'b0, 1'b1, 8'h03);
        cycle(1'b0, 1'b1, 8'h05);
        chk("v_validate", int'(debug_state), 2);
        cycle(1'b0, 1'b0, 8'h00);
        chk("v_rdy", int'(command_ready), 1);
        chk("v_cmd", int'(command), 8'h03);
        chk("v_addr", int'(address), 8'h05);
        chk("v_ferr", int'(frame_error), 0);
        cycle(1'b0, 1'b0, 8'h00);
        chk("v_rdy_drop", int'(command_ready), 0);

        // Bad command 0x09, with stray bytes in VALIDATE and ERROR
        cycle(1'b0, 1'b1, 8'h09);
        cycle(1'b0, 1'b1, 8'h05);
        cycle(1'b0, 1'b1, 8'h01);
        chk("bc_ferr", int'(frame_error), 1);
        chk("bc_code", int'(error_code), 1);
        chk("bc_cmd_held", int'(command), 8'h03);
        chk("bc_addr_held", int'(address), 8'h05);
        cycle(1'b0, 1'b1, 8'h01);
        chk("bc_ignored", int'(debug_state), 0);
        cycle(1'b0, 1'b0, 8'h00);

        // Bad address 0x02, 0x20
        cycle(1'b0, 1'b1, 8'h02);
        cycle(1'b0, 1'b1, 8'h20);
        cycle(1'b0, 1'b0, 8'h00);
        chk("ba_code", int'(error_code), 2);
        chk("ba_rdy", int'(command_ready), 0);
        cycle(1'b0, 1'b0, 8'h00);

        // Timeout after byte 0x01
        cycle(1'b0, 1'b1, 8'h01);
        repeat (TO - 1) cycle(1'b0, 1'b0, 8'h00);
        chk("to_not_yet", int'(frame_error), 0);
        cycle(1'b0, 1'b0, 8'h00);
        chk("to_ferr", int'(frame_error), 1);
        chk("to_code", int'(error_code), 3);
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 8'h01);
        cycle(1'b0, 1'b1, 8'h02);
        cycle(1'b0, 1'b0, 8'h00);
        chk("after_to_rdy", int'(command_ready), 1);
        chk("after_to_addr", int'(address), 8'h02);
        cycle(1'b0, 1'b0, 8'h00);

        // Second byte exactly on terminal count; limits 0x06/0x1F
        cycle(1'b0, 1'b1, 8'h06);
        repeat (TO - 1) cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 8'h1F);
        cycle(1'b0, 1'b0, 8'h00);
        chk("edge_rdy", int'(command_ready), 1);
        chk("edge_cmd", int'(command), 8'h06);
        chk("edge_addr", int'(address), 8'h1F);
        cycle(1'b0, 1'b0, 8'h00);

        // Command 0x07 rejected
        cycle(1'b0, 1'b1, 8'h07);
        cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
        chk("c7_code", int'(error_code), 1);
        cycle(1'b0, 1'b0, 8'h00);

        // Reset after byte 1, then frame 0x00, 0x00
        cycle(1'b0, 1'b1, 8'h04);
        cycle(1'b1, 1'b0, 8'h00);
        repeat (3) cycle(1'b0, 1'b0, 8'h00);
        chk("rst_mid_ferr", int'(frame_error), 0);
        cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
        chk("rst_mid_rdy", int'(command_ready), 1);
        chk("rst_mid_cmd", int'(command), 0);
        cycle(1'b0, 1'b0, 8'h00);

        // Randomized streams: dense phases and sparse (timeout-prone) phases
        for (int i = 0; i < 4000; i++) begin
            int p;
            bit h;
            bit r;
            logic [7:0] d;
            p = ((i / 500) % 2 == 0) ? 30 : 1;
            h = ($urandom_range(0, 99) < p);
            r = ($urandom_range(0, 299) == 0);
            d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                             : 8'($urandom_range(0, 40));
            cycle(r, h, d);
        end

        @(negedge clock);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_command_decoder.md
# uart_command_decoder

Receive-side frame decoder for the host-to-FPGA command link. Consumes the byte stream delivered by `UART_RX`, which presents one byte per `has_data` pulse, and assembles two-byte frames of the form command byte then address byte. Each frame is validated, with an inter-byte timeout, and emitted as a single-cycle command strobe toward the sensor controller. Malformed or stalled frames produce a one-cycle error strobe with a reason code.

## Interface
- `TIMEOUT_CYCLES`, default 43400: maximum clocks allowed between byte 1 and byte 2 (about 10 byte times at 115200 baud and 50 MHz).
- `NUM_COMMANDS`, default 7: command bytes 0x00 to NUM_COMMANDS-1 are legal.
- `MAX_ADDRESS`, default 31: address bytes 0x00 to MAX_ADDRESS are legal.
- `clock`, input, 1: single system clock. All logic is on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `has_data`, input, 1: one-cycle pulse from `UART_RX`; `data_received` is valid in the same cycle.
- `data_received`, input, 8: received byte.
- `command_ready`, output, 1: one-cycle strobe indicating a validated frame.
- `command`, output, 8: command of the last valid frame; held between frames.
- `address`, output, 8: address of the last valid frame; held between frames.
- `frame_error`, output, 1: one-cycle strobe indicating a rejected frame.
- `error_code`, output, 2: 01 = bad command, 10 = bad address, 11 = timeout. Held until the next `frame_error`.
- `debug_state`, output, 3: current FSM state encoding.

## Operation
- FSM states and encodings: IDLE = 0, WAIT_ADDR = 1, VALIDATE = 2, DONE = 3, ERROR = 4.
- IDLE:
  - On `has_data`, latch `data_received` into an internal command register.
  - Clear the timeout counter and go to WAIT_ADDR.
- WAIT_ADDR:
  - The timeout counter increments every cycle.
  - On `has_data`, latch the internal address register and go to VALIDATE.
  - Else, if the counter equals TIMEOUT_CYCLES-1, set `error_code` = 11 and go to ERROR.
- VALIDATE, one cycle:
  - If command >= NUM_COMMANDS, set `error_code` = 01 and go to ERROR.
  - Else, if address > MAX_ADDRESS, set `error_code` = 10 and go to ERROR.
  - Else, copy the internal registers to the `command` and `address` outputs and go to DONE.
  - The command check has priority over the address check.
- DONE: `command_ready` = 1; go to IDLE.
- ERROR: `frame_error` = 1; go to IDLE. The `command` and `address` outputs are unchanged.
- `has_data` arriving in VALIDATE, DONE or ERROR is ignored, with no state or register effect.
  - UART byte spacing of at least 10 bit times makes this unreachable in-system; the bench still checks it.
- Counter width is $clog2(TIMEOUT_CYCLES). The counter saturates and never wraps; it is cleared on every entry to WAIT_ADDR.
- `command_ready` and `frame_error` are decoded from state and are never high together.

## Timing
- Reset, sampled high at an edge, forces at that edge:
  - state = IDLE;
  - `command` = 0x00, `address` = 0x00, `error_code` = 00;
  - `command_ready` = 0, `frame_error` = 0;
  - `debug_state` = 0;
  - timeout counter = 0.
- Reset asserted mid-frame (WAIT_ADDR or VALIDATE) discards the partial frame silently, with no `frame_error`.
- Latency, with edge N sampling the second `has_data`:
  - VALIDATE occupies the cycle after N.
  - `command_ready` or `frame_error` is high in the cycle after N+1 and is sampled high at edge N+2.
- Outputs valid with the strobe: `command`, `address` and `error_code` are valid in the same cycle as their strobe.
- Timeout, with edge T sampling the first `has_data`:
  - With no second byte, `frame_error` is sampled high at edge T+TIMEOUT_CYCLES+1.
- Simultaneous `has_data` and terminal count in WAIT_ADDR: `has_data` wins and the frame proceeds to VALIDATE.
- Back-to-back frames: a new byte 1 is accepted in the first cycle that state = IDLE.

## Test plan
- Valid frame, bytes 0x03 then 0x05:
  - Required: `command_ready` pulse exactly 2 edges after the second byte, with `command` = 0x03 and `address` = 0x05.
  - `frame_error` stays 0.
- Bad command 0x09 with address 0x05:
  - Required: `frame_error` pulse with `error_code` = 01.
  - `command` and `address` keep the prior values 0x03 and 0x05.
- Bad address, command 0x02 with address 0x20:
  - Required: `error_code` = 10 and no `command_ready`.
- Timeout, with TIMEOUT_CYCLES = 100 and only byte 0x01 sent:
  - Required: `frame_error` with `error_code` = 11 sampled at edge T+101.
  - A following frame 0x01, 0x02 then decodes correctly.
- Boundary on timeout:
  - Second byte at counter = 99, coincident with the terminal count: the frame is accepted.
  - Command 0x06 with address 0x1F: accepted.
  - Command 0x07: rejected with `error_code` = 01.
- Reset after byte 1, with 0x04 then the next frame 0x00, 0x00:
  - Required: no error from the aborted frame.
  - The next frame gives `command_ready` with 0x00, 0x00.
